// File: rtl/recirculador_param_if.sv
// Lane bus for recirculador_param: the upstream lane source drives the master side,
// and the recirculator consumes it through the slave side.
// RECIRC_STATS_EN adds the per-lane statistics counter bus.
interface recirculador_param_if #(
   parameter int LANES = 4,
   parameter int WIDTH = 8
`ifdef RECIRC_STATS_EN
   ,parameter int CNT_W = 16
`endif
);
   logic                   idle;
   logic [LANES*WIDTH-1:0] data_in;
   logic [LANES-1:0]       valid_in;
   logic [LANES*WIDTH-1:0] data_out_logic;
   logic [LANES-1:0]       valid_out_logic;
   logic [LANES*WIDTH-1:0] data_out_recirc;
   logic [LANES-1:0]       valid_out_recirc;
   logic [LANES-1:0]       recirc_pop;
   logic [LANES-1:0]       recirc_full;
   logic                   mode;
   logic                   drop_err;
`ifdef RECIRC_STATS_EN
   logic [LANES*CNT_W-1:0] recirc_count;
`endif

   modport master (
      output idle, data_in, valid_in, recirc_pop,
      input  data_out_logic, valid_out_logic, data_out_recirc, valid_out_recirc,
      input  recirc_full, mode, drop_err
`ifdef RECIRC_STATS_EN
      ,input recirc_count
`endif
   );

   modport slave (
      input  idle, data_in, valid_in, recirc_pop,
      output data_out_logic, valid_out_logic, data_out_recirc, valid_out_recirc,
      output recirc_full, mode, drop_err
`ifdef RECIRC_STATS_EN
      ,output recirc_count
`endif
   );
endinterface

// File: rtl/recirculador_param.sv
// Parametrised PHY TX lane recirculator.
// In PASS mode, lane words go to the registered logic path.
// In RECIRC mode, each lane's words go into its own first-word-fall-through FIFO,
// which is drained by a pop handshake.
// A mode change only happens on a cycle with no valid words,
// so a frame is never split across the two paths.
// Optional feature macro RECIRC_STATS_EN adds saturating per-lane accepted-push counters.
module recirculador_param #(
   parameter int LANES = 4,
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
`ifdef RECIRC_STATS_EN
   ,parameter int CNT_W = 16
`endif
) (
   input  logic                clk,
   input  logic                reset_L,
   recirculador_param_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [PTR_W:0]   count_t;

   localparam count_t FULL_CNT = count_t'(DEPTH);

   typedef enum logic {PASS = 1'b0, RECIRC = 1'b1} mode_e;

   mode_e                  mode_q;
   logic [LANES*WIDTH-1:0] dataLogic_q;
   logic [LANES-1:0]       validLogic_q;
   logic                   dropErr_q;
   logic [LANES-1:0]       laneDrop;

   // Mode FSM: switch only on a word boundary (no lane valid), otherwise hold the current mode
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         mode_q <= PASS;
      end else begin
         case (mode_q)
            PASS:    if (bus.idle && (bus.valid_in == '0)) mode_q <= RECIRC;
            RECIRC:  if (!bus.idle && (bus.valid_in == '0)) mode_q <= PASS;
            default: mode_q <= PASS;
         endcase
      end
   end

   // Logic path register: capture valid words in PASS, keep data and drop valids in RECIRC
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         dataLogic_q  <= '0;
         validLogic_q <= '0;
      end else if (mode_q == PASS) begin
         validLogic_q <= bus.valid_in;
         for (int i = 0; i < LANES; i++) begin
            if (bus.valid_in[i]) begin
               dataLogic_q[i*WIDTH +: WIDTH] <= bus.data_in[i*WIDTH +: WIDTH];
            end
         end
      end else begin
         validLogic_q <= '0;
      end
   end

   // Sticky overflow flag: any lane dropping a word sets it until reset
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         dropErr_q <= 1'b0;
      end else if (|laneDrop) begin
         dropErr_q <= 1'b1;
      end
   end

   assign bus.data_out_logic  = dataLogic_q;
   assign bus.valid_out_logic = validLogic_q;
   assign bus.mode            = (mode_q == RECIRC);
   assign bus.drop_err        = dropErr_q;

   for (genvar g = 0; g < LANES; g++) begin : gLane
      logic [WIDTH-1:0] mem_q [DEPTH];
      ptr_t             rdPtr_q;
      ptr_t             wrPtr_q;
      count_t           count_q;
      count_t           count_d;
      logic             pushReq;
      logic             popOk;
      logic             pushOk;

      // Push/pop qualification: a pop on an empty FIFO is ignored,
      // and a push into a full FIFO only succeeds when a real pop frees a slot in the same cycle
      always_comb begin
         pushReq = (mode_q == RECIRC) && bus.valid_in[g];
         popOk   = bus.recirc_pop[g] && (count_q != '0);
         pushOk  = pushReq && ((count_q != FULL_CNT) || popOk);
         count_d = count_q;
         if (pushOk && !popOk) begin
            count_d = count_q + count_t'(1);
         end else if (!pushOk && popOk) begin
            count_d = count_q - count_t'(1);
         end
      end

      assign laneDrop[g] = pushReq && !pushOk;

      // Circular buffer storage; pointers wrap naturally because DEPTH is a power of two
      always_ff @(posedge clk or negedge reset_L) begin
         if (!reset_L) begin
            for (int d = 0; d < DEPTH; d++) begin
               mem_q[d] <= '0;
            end
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
         end else begin
            if (pushOk) begin
               mem_q[wrPtr_q] <= bus.data_in[g*WIDTH +: WIDTH];
               wrPtr_q        <= wrPtr_q + ptr_t'(1);
            end
            if (popOk) begin
               rdPtr_q <= rdPtr_q + ptr_t'(1);
            end
            count_q <= count_d;
         end
      end

      assign bus.data_out_recirc[g*WIDTH +: WIDTH] = mem_q[rdPtr_q];
      assign bus.valid_out_recirc[g]               = (count_q != '0);
      assign bus.recirc_full[g]                    = (count_q == FULL_CNT);

`ifdef RECIRC_STATS_EN
      logic [CNT_W-1:0] stat_q;

      // Accepted-push counter, saturating at all-ones
      always_ff @(posedge clk or negedge reset_L) begin
         if (!reset_L) begin
            stat_q <= '0;
         end else if (pushOk && (stat_q != '1)) begin
            stat_q <= stat_q + CNT_W'(1);
         end
      end

      assign bus.recirc_count[g*CNT_W +: CNT_W] = stat_q;
`endif
   end
endmodule

// File: tb/tb_recirculador_param.sv
// Directed testbench for recirculador_param (LANES=4, WIDTH=8, DEPTH=4).
// With RECIRC_STATS_EN defined, the bench uses CNT_W=2 and also checks counter saturation.
module tb_recirculador_param;
   logic clk;
   logic reset_L;
   int   compareCount;
   int   errorCount;

   recirculador_param_if #(
      .LANES(4),
      .WIDTH(8)
`ifdef RECIRC_STATS_EN
      ,.CNT_W(2)
`endif
   ) bus ();

   recirculador_param #(
      .LANES(4),
      .WIDTH(8),
      .DEPTH(4)
`ifdef RECIRC_STATS_EN
      ,.CNT_W(2)
`endif
   ) dut (
      .clk    (clk),
      .reset_L(reset_L),
      .bus    (bus)
   );

   // Free-running clock, period 10
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drive one input vector, then let one rising edge consume it; sample 1 after the edge
   task automatic applyStimulus(input logic idleV, input logic [31:0] dataV,
                                input logic [3:0] validV, input logic [3:0] popV);
      bus.idle       = idleV;
      bus.data_in    = dataV;
      bus.valid_in   = validV;
      bus.recirc_pop = popV;
      @(posedge clk);
      #1;
   endtask

   // Directed test sequence
   initial begin
      compareCount   = 0;
      errorCount     = 0;
      reset_L        = 1'b0;
      bus.idle       = 1'b0;
      bus.data_in    = '0;
      bus.valid_in   = '0;
      bus.recirc_pop = '0;

      #12;
      checkOutput("rst_mode", {31'b0, bus.mode}, 32'h0);
      checkOutput("rst_vol", {28'b0, bus.valid_out_logic}, 32'h0);
      checkOutput("rst_dol", bus.data_out_logic, 32'h0);
      checkOutput("rst_vor", {28'b0, bus.valid_out_recirc}, 32'h0);
      checkOutput("rst_full", {28'b0, bus.recirc_full}, 32'h0);
      checkOutput("rst_dor", bus.data_out_recirc, 32'h0);
      checkOutput("rst_drop", {31'b0, bus.drop_err}, 32'h0);
      @(negedge clk);
      reset_L = 1'b1;

      applyStimulus(1'b0, 32'h0D0C0B0A, 4'hF, 4'h0);
      checkOutput("pass_dol", bus.data_out_logic, 32'h0D0C0B0A);
      checkOutput("pass_vol", {28'b0, bus.valid_out_logic}, 32'hF);
      checkOutput("pass_mode", {31'b0, bus.mode}, 32'h0);
      checkOutput("pass_vor", {28'b0, bus.valid_out_recirc}, 32'h0);

      applyStimulus(1'b1, 32'h43424140, 4'hF, 4'h0);
      checkOutput("defer1_mode", {31'b0, bus.mode}, 32'h0);
      checkOutput("defer1_dol", bus.data_out_logic, 32'h43424140);
      applyStimulus(1'b1, 32'h53525150, 4'hF, 4'h0);
      checkOutput("defer2_mode", {31'b0, bus.mode}, 32'h0);
      checkOutput("defer2_dol", bus.data_out_logic, 32'h53525150);
      applyStimulus(1'b1, 32'h63626160, 4'h5, 4'h0);
      checkOutput("defer3_mode", {31'b0, bus.mode}, 32'h0);
      checkOutput("defer3_dol", bus.data_out_logic, 32'h53625160);
      checkOutput("defer3_vol", {28'b0, bus.valid_out_logic}, 32'h5);

      applyStimulus(1'b1, 32'h0, 4'h0, 4'h0);
      checkOutput("enter_mode", {31'b0, bus.mode}, 32'h1);
      checkOutput("enter_vol", {28'b0, bus.valid_out_logic}, 32'h0);

      applyStimulus(1'b1, 32'h13121110, 4'hF, 4'h0);
      checkOutput("rc_vor", {28'b0, bus.valid_out_recirc}, 32'hF);
      checkOutput("rc_dor", bus.data_out_recirc, 32'h13121110);
      checkOutput("rc_vol", {28'b0, bus.valid_out_logic}, 32'h0);
      checkOutput("rc_dol_hold", bus.data_out_logic, 32'h53625160);

      applyStimulus(1'b1, 32'h0, 4'h0, 4'hF);
      checkOutput("drain_vor", {28'b0, bus.valid_out_recirc}, 32'h0);
      checkOutput("drain_mode", {31'b0, bus.mode}, 32'h1);

      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 32'h20 + k, 4'h1, 4'h0);
      end
      checkOutput("fill_full", {28'b0, bus.recirc_full}, 32'h1);
      checkOutput("fill_head", {24'b0, bus.data_out_recirc[7:0]}, 32'h20);
      checkOutput("fill_vor", {28'b0, bus.valid_out_recirc}, 32'h1);

      applyStimulus(1'b1, 32'h30, 4'h1, 4'h1);
      checkOutput("pp_full_head", {24'b0, bus.data_out_recirc[7:0]}, 32'h21);
      checkOutput("pp_full_full", {28'b0, bus.recirc_full}, 32'h1);
      checkOutput("pp_full_drop", {31'b0, bus.drop_err}, 32'h0);

      applyStimulus(1'b1, 32'h24, 4'h1, 4'h0);
      checkOutput("ovf_drop", {31'b0, bus.drop_err}, 32'h1);
      checkOutput("ovf_head", {24'b0, bus.data_out_recirc[7:0]}, 32'h21);
      checkOutput("ovf_full", {28'b0, bus.recirc_full}, 32'h1);

      applyStimulus(1'b1, 32'h0, 4'h0, 4'h1);
      checkOutput("pop1_head", {24'b0, bus.data_out_recirc[7:0]}, 32'h22);
      checkOutput("pop1_full", {28'b0, bus.recirc_full}, 32'h0);
      applyStimulus(1'b1, 32'h0, 4'h0, 4'h1);
      checkOutput("pop2_head", {24'b0, bus.data_out_recirc[7:0]}, 32'h23);
      applyStimulus(1'b1, 32'h0, 4'h0, 4'h1);
      checkOutput("pop3_head", {24'b0, bus.data_out_recirc[7:0]}, 32'h30);
      applyStimulus(1'b1, 32'h0, 4'h0, 4'h1);
      checkOutput("pop4_vor", {28'b0, bus.valid_out_recirc}, 32'h0);
      checkOutput("pop4_drop", {31'b0, bus.drop_err}, 32'h1);

      applyStimulus(1'b1, 32'h0, 4'h0, 4'h1);
      checkOutput("popempty_vor", {28'b0, bus.valid_out_recirc}, 32'h0);
      checkOutput("popempty_full", {28'b0, bus.recirc_full}, 32'h0);

      applyStimulus(1'b1, 32'h55, 4'h1, 4'h1);
      checkOutput("ppempty_vor", {28'b0, bus.valid_out_recirc}, 32'h1);
      checkOutput("ppempty_head", {24'b0, bus.data_out_recirc[7:0]}, 32'h55);
      applyStimulus(1'b1, 32'h0, 4'h0, 4'h1);
      checkOutput("ppempty_drain", {28'b0, bus.valid_out_recirc}, 32'h0);

      applyStimulus(1'b1, 32'h73727170, 4'hF, 4'h0);
      applyStimulus(1'b1, 32'h83828180, 4'hF, 4'h0);
      checkOutput("two_vor", {28'b0, bus.valid_out_recirc}, 32'hF);
      checkOutput("two_dor", bus.data_out_recirc, 32'h73727170);

      bus.idle     = 1'b0;
      bus.valid_in = 4'h0;
      reset_L      = 1'b0;
      #1;
      checkOutput("midrst_vor", {28'b0, bus.valid_out_recirc}, 32'h0);
      checkOutput("midrst_dor", bus.data_out_recirc, 32'h0);
      checkOutput("midrst_mode", {31'b0, bus.mode}, 32'h0);
      checkOutput("midrst_drop", {31'b0, bus.drop_err}, 32'h0);
      checkOutput("midrst_dol", bus.data_out_logic, 32'h0);
      @(negedge clk);
      reset_L = 1'b1;
      applyStimulus(1'b0, 32'h0, 4'h0, 4'h0);
      checkOutput("postrst_vor", {28'b0, bus.valid_out_recirc}, 32'h0);
      checkOutput("postrst_mode", {31'b0, bus.mode}, 32'h0);

`ifdef RECIRC_STATS_EN
      applyStimulus(1'b1, 32'h0, 4'h0, 4'h0);
      checkOutput("stat_mode", {31'b0, bus.mode}, 32'h1);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 32'h0000A000 + (k << 8), 4'h2, 4'h0);
      end
      checkOutput("stat_cnt3", {24'b0, bus.recirc_count}, 32'h0C);
      for (int k = 0; k < 2; k++) begin
         applyStimulus(1'b1, 32'h0000B000 + (k << 8), 4'h2, 4'h2);
      end
      checkOutput("stat_sat", {24'b0, bus.recirc_count}, 32'h0C);
      checkOutput("stat_drop", {31'b0, bus.drop_err}, 32'h0);
      checkOutput("stat_vor", {28'b0, bus.valid_out_recirc}, 32'h2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
      $finish;
   end
endmodule
